neuron_sample_feeder: RTL and testbench
=======================================

Name: neuron_sample_feeder

Overview:
- Responder side of the perceptron training-data handshake: answers the neuron's requestFlag with one (x1, x2, t) sample and dataReady, cycling through the stored set epoch after epoch.
- Holds the training set in an internal sync-read memory, filled sequentially over a load port before training starts.
- Replaces bench-side sample driving; sits between the data-set loader and the neuron core.

Parameters:
- DEPTH, 512, maximum number of stored samples.
- ADDR_W, 9, address width; must satisfy 2**ADDR_W >= DEPTH.
- X_W, 7, signed width of x1/x2.
- T_W, 2, signed width of target t.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- load_valid  in  1  push one sample into memory at the next free address.
- load_x1  in  X_W  signed sample x1 to load.
- load_x2  in  X_W  signed sample x2 to load.
- load_t  in  T_W  signed target to load.
- clear  in  1  empty the memory (count to 0); honoured only in IDLE.
- start  in  1  begin serving; honoured only in IDLE.
- requestFlag  in  1  level request from the neuron.
- done  in  1  neuron training finished; feeder returns to IDLE.
- x1Input  out  X_W  presented sample x1.
- x2Input  out  X_W  presented sample x2.
- tInput  out  T_W  presented sample t.
- dataReady  out  1  sample valid; 4-phase acknowledge.
- nInput  out  32  stored sample count, zero-extended.
- epoch  out  16  completed passes over the set.
- epoch_wrap  out  1  one-cycle pulse when the index wraps to 0.
- load_full  out  1  count == DEPTH.

Behaviour:
- Reset: all outputs 0; count=0, idx=0, epoch=0; state IDLE. Memory contents are not cleared.
- States: IDLE, ARM, FETCH, PRESENT, RELEASE.
- IDLE:
  - load_valid && !load_full writes mem[count] and increments count next cycle; load_valid while full is dropped.
  - clear sets count=0.
  - start && count>0 -> ARM, with idx=0 and epoch=0. start with count==0 is ignored.
- ARM: requestFlag=1 -> FETCH, issuing a read of mem[idx].
- FETCH: read data returns after 1 cycle; register it onto the x1Input/x2Input/tInput outputs -> PRESENT.
- PRESENT:
  - dataReady=1; data outputs stable.
  - Hold until requestFlag=0, then dataReady=0 next cycle -> RELEASE.
- RELEASE:
  - idx = idx+1.
  - If idx+1 == count: idx=0, epoch+=1 (saturating at 0xFFFF), epoch_wrap=1 for this one cycle.
  - -> ARM.
- Latency: requestFlag rise to dataReady rise = 2 cycles (ARM sample, FETCH).
- Data outputs keep the last presented sample outside PRESENT.
- done=1 in any non-IDLE state -> IDLE next cycle; dataReady=0 the same edge. done outranks requestFlag.
- While not IDLE, load_valid, clear and start are ignored.
- Mid-operation reset behaves exactly as power-on reset. Stored samples survive, but count=0, so the set must be reloaded.
- nInput = count, stable across serving.
- Signedness is stored and forwarded verbatim; no arithmetic on the data.

Optional Feature:
- Macro: FEEDER_EPOCH_LIMIT_EN.
- With it defined:
  - Extra ports: epoch_limit (in, 16) and exhausted (out, 1).
  - On the RELEASE wrap that makes epoch == epoch_limit (limit != 0): go to IDLE and set exhausted=1.
  - exhausted is sticky until the next accepted start or reset.
  - epoch_limit == 0 means unlimited.
- Without it: ports absent, unlimited epochs, only done ends serving.

Decomposition:
- Shared package neuron_pkg:
  - Widths X_W, T_W, weight width (14), NCOUNT_W (32).
  - Feeder state enum.
  - Packed sample struct {x1, x2, t}.
- One sub-module: feeder_sample_mem.
  - DEPTH x (2*X_W+T_W) single-port RAM, synchronous write, registered 1-cycle read.
  - Write and read are never concurrent, because loads happen only in IDLE.

Test Plan:
- Load 3 samples (5,-3,1), (-64,63,-1), (0,1,1); start; toggle requestFlag 4 times -> samples 0,1,2,0 presented in order. epoch_wrap pulses once after sample 2. epoch=1, nInput=3.
- Hold requestFlag high 10 cycles -> dataReady rises exactly 2 cycles after the request and stays high, data stable. Drop the request -> dataReady low next cycle, idx advances once.
- Load DEPTH+2 samples -> load_full=1 and nInput=512; extra pushes dropped. start with count=0 after clear -> state stays IDLE, dataReady never rises.
- Assert done during PRESENT -> dataReady=0 next cycle, state IDLE. A fresh start restarts at sample 0 with epoch=0.
- Assert rst mid-PRESENT -> all outputs 0, nInput=0; a later start is ignored until a reload.
- With FEEDER_EPOCH_LIMIT_EN, epoch_limit=2, 2 samples -> exactly 4 presentations, then exhausted=1 and IDLE. Further requests get no dataReady.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and widths for the perceptron neuron and its sample feeder.
package neuron_pkg;

  localparam int X_W      = 7;   // signed sample width
  localparam int T_W      = 2;   // signed target width
  localparam int WEIGHT_W = 14;  // neuron weight width
  localparam int NCOUNT_W = 32;  // width of the sample-count bus

  // Feeder handshake states
  typedef enum logic [2:0] {
    FS_IDLE    = 3'd0,
    FS_ARM     = 3'd1,
    FS_FETCH   = 3'd2,
    FS_PRESENT = 3'd3,
    FS_RELEASE = 3'd4
  } feeder_state_e;

  // One training sample as stored in the feeder memory
  typedef struct packed {
    logic [X_W-1:0] x1;
    logic [X_W-1:0] x2;
    logic [T_W-1:0] t;
  } sample_t;

endpackage

// File: rtl/feeder_sample_mem.sv
// Single-port sample RAM: synchronous write, registered one-cycle read.
// Writes (loading) and reads (serving) never happen in the same cycle.
module feeder_sample_mem #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int W      = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem_array [DEPTH];

  // Write port and registered read port sharing one address
  always_ff @(posedge clk) begin
    if (we) mem_array[addr] <= wdata;
    if (re) rdata <= mem_array[addr];
  end

endmodule

// File: rtl/neuron_sample_feeder.sv
// Training-sample responder for the perceptron neuron: loads a sample set
// in IDLE, then answers each requestFlag with one (x1, x2, t) and a 4-phase
// dataReady, cycling epoch after epoch until done.
// Optional macro FEEDER_EPOCH_LIMIT_EN adds epoch_limit/exhausted: serving
// stops by itself once the configured number of epochs completes.
module neuron_sample_feeder #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int X_W    = 7,
  parameter int T_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [X_W-1:0]    load_x1,
  input  logic [X_W-1:0]    load_x2,
  input  logic [T_W-1:0]    load_t,
  input  logic              clear,
  input  logic              start,
  input  logic              requestFlag,
  input  logic              done,
  output logic [X_W-1:0]    x1Input,
  output logic [X_W-1:0]    x2Input,
  output logic [T_W-1:0]    tInput,
  output logic              dataReady,
  output logic [31:0]       nInput,
  output logic [15:0]       epoch,
  output logic              epoch_wrap,
`ifdef FEEDER_EPOCH_LIMIT_EN
  input  logic [15:0]       epoch_limit,
  output logic              exhausted,
`endif
  output logic              load_full
);

  import neuron_pkg::*;

  localparam int MEM_W = 2*X_W + T_W;
  localparam logic [2:0] IDLE    = FS_IDLE;
  localparam logic [2:0] ARM     = FS_ARM;
  localparam logic [2:0] FETCH   = FS_FETCH;
  localparam logic [2:0] PRESENT = FS_PRESENT;
  localparam logic [2:0] RELEASE = FS_RELEASE;

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [15:0]       epoch_reg;
  logic              wrap_reg;
  logic              ready_reg;
  logic [X_W-1:0]    x1_reg, x2_reg;
  logic [T_W-1:0]    t_reg;

  logic [ADDR_W:0]   idx_inc;
  logic [15:0]       epoch_inc;
  logic              is_full, do_load, do_start, at_wrap, limit_hit;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata;

  assign is_full   = (count_reg == (ADDR_W+1)'(DEPTH));
  assign do_load   = (state_reg == IDLE) && load_valid && !is_full && !clear;
  assign do_start  = (state_reg == IDLE) && start && !clear && (count_reg != '0);
  assign idx_inc   = {1'b0, idx_reg} + 1'b1;
  assign at_wrap   = (idx_inc == count_reg);
  assign epoch_inc = (epoch_reg == 16'hFFFF) ? epoch_reg : epoch_reg + 16'd1;

`ifdef FEEDER_EPOCH_LIMIT_EN
  assign limit_hit = (epoch_limit != 16'd0) && (epoch_inc == epoch_limit);
`else
  assign limit_hit = 1'b0;
`endif

  // Memory is written at the fill pointer in IDLE and read at idx otherwise
  assign mem_we    = do_load;
  assign mem_re    = (state_reg == ARM) && requestFlag && !done;
  assign mem_addr  = (state_reg == IDLE) ? count_reg[ADDR_W-1:0] : idx_reg;
  assign mem_wdata = {load_x1, load_x2, load_t};

  feeder_sample_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (MEM_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Next-state logic; done outranks every handshake condition
  always_comb begin
    state_next = state_reg;
    if (state_reg != IDLE && done) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (do_start) state_next = ARM;
        ARM:     if (requestFlag) state_next = FETCH;
        FETCH:   state_next = PRESENT;
        PRESENT: if (!requestFlag) state_next = RELEASE;
        RELEASE: state_next = (at_wrap && limit_hit) ? IDLE : ARM;
        default: state_next = IDLE;
      endcase
    end
  end

  // State, counters, presented sample and handshake flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      idx_reg   <= '0;
      epoch_reg <= '0;
      wrap_reg  <= 1'b0;
      ready_reg <= 1'b0;
      x1_reg    <= '0;
      x2_reg    <= '0;
      t_reg     <= '0;
    end else begin
      state_reg <= state_next;
      wrap_reg  <= 1'b0;
      if (state_reg == IDLE) begin
        if (clear)        count_reg <= '0;
        else if (do_load) count_reg <= count_reg + 1'b1;
        if (do_start) begin
          idx_reg   <= '0;
          epoch_reg <= '0;
        end
      end
      if (state_reg == FETCH && !done) begin
        x1_reg    <= mem_rdata[MEM_W-1 -: X_W];
        x2_reg    <= mem_rdata[T_W +: X_W];
        t_reg     <= mem_rdata[T_W-1:0];
        ready_reg <= 1'b1;
      end
      if (state_reg == PRESENT && (done || !requestFlag)) ready_reg <= 1'b0;
      if (state_reg == RELEASE && !done) begin
        if (at_wrap) begin
          idx_reg   <= '0;
          epoch_reg <= epoch_inc;
          wrap_reg  <= 1'b1;
        end else begin
          idx_reg   <= idx_inc[ADDR_W-1:0];
        end
      end
    end
  end

`ifdef FEEDER_EPOCH_LIMIT_EN
  logic exhausted_reg;

  // Sticky end-of-training flag, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      exhausted_reg <= 1'b0;
    end else if (do_start) begin
      exhausted_reg <= 1'b0;
    end else if (state_reg == RELEASE && !done && at_wrap && limit_hit) begin
      exhausted_reg <= 1'b1;
    end
  end

  assign exhausted = exhausted_reg;
`endif

  assign x1Input    = x1_reg;
  assign x2Input    = x2_reg;
  assign tInput     = t_reg;
  assign dataReady  = ready_reg;
  assign nInput     = NCOUNT_W'(count_reg);
  assign epoch      = epoch_reg;
  assign epoch_wrap = wrap_reg;
  assign load_full  = is_full;

endmodule

// File: tb/tb_neuron_sample_feeder.sv
// Scoreboard bench for neuron_sample_feeder: stimulus pushes the sample it
// expects on each request, a negedge monitor pops and compares it whenever
// dataReady rises. Honours FEEDER_EPOCH_LIMIT_EN when defined.
module tb_neuron_sample_feeder;
  import neuron_pkg::*;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [6:0]  load_x1 = '0, load_x2 = '0;
  logic [1:0]  load_t = '0;
  logic        clear = 1'b0, start = 1'b0, requestFlag = 1'b0, done = 1'b0;
  logic [6:0]  x1Input, x2Input;
  logic [1:0]  tInput;
  logic        dataReady;
  logic [31:0] nInput;
  logic [15:0] epoch;
  logic        epoch_wrap;
  logic        load_full;
`ifdef FEEDER_EPOCH_LIMIT_EN
  logic [15:0] epoch_limit = '0;
  logic        exhausted;
`endif

  neuron_sample_feeder dut (
    .clk(clk), .rst(rst), .load_valid(load_valid),
    .load_x1(load_x1), .load_x2(load_x2), .load_t(load_t),
    .clear(clear), .start(start), .requestFlag(requestFlag), .done(done),
    .x1Input(x1Input), .x2Input(x2Input), .tInput(tInput),
    .dataReady(dataReady), .nInput(nInput), .epoch(epoch),
    .epoch_wrap(epoch_wrap),
`ifdef FEEDER_EPOCH_LIMIT_EN
    .epoch_limit(epoch_limit), .exhausted(exhausted),
`endif
    .load_full(load_full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the stored set and serving position
  sample_t mmem [DEPTH];
  int      mcount = 0;
  int      midx = 0;
  int      mepoch = 0;
  int      mlimit = 0;
  bit      mexh = 0;
  sample_t exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop an expected sample on each dataReady rise, then hold it stable
  initial begin
    sample_t cur;
    bit prev = 1'b0;
    bit have = 1'b0;
    forever begin
      @(negedge clk);
      if (dataReady && !prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_dataReady actual=1 required=0");
          have = 1'b0;
        end else begin
          cur  = exp_q.pop_front();
          have = 1'b1;
          check("x1", x1Input, cur.x1);
          check("x2", x2Input, cur.x2);
          check("t", tInput, cur.t);
        end
      end else if (dataReady && have) begin
        check("hold_x1", x1Input, cur.x1);
        check("hold_t", tInput, cur.t);
      end
      prev = dataReady;
    end
  end

  task automatic load(input logic [6:0] a, input logic [6:0] b, input logic [1:0] c);
    load_valid = 1'b1; load_x1 = a; load_x2 = b; load_t = c;
    tick();
    load_valid = 1'b0;
    if (mcount < DEPTH) begin
      mmem[mcount] = '{x1: a, x2: b, t: c};
      mcount++;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    mcount = 0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
    if (mcount > 0) begin
      midx = 0; mepoch = 0; mexh = 0;
    end
  endtask

  task automatic do_done();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  // One full 4-phase transfer with the request held `hold` extra cycles
  task automatic request_cycle(input int hold);
    int lat;
    bit wrap;
    exp_q.push_back(mmem[midx]);
    requestFlag = 1'b1;
    lat = 0;
    while (!dataReady && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", lat, 2);
    repeat (hold) tick();
    requestFlag = 1'b0;
    tick();
    check("ready_drop", dataReady, 0);
    tick();
    midx++;
    wrap = 1'b0;
    if (midx == mcount) begin
      midx = 0;
      if (mepoch != 16'hFFFF) mepoch++;
      wrap = 1'b1;
      if (mlimit != 0 && mepoch == mlimit) mexh = 1'b1;
    end
    check("epoch_wrap", epoch_wrap, wrap);
    check("epoch", epoch, mepoch);
  endtask

  // Request that must not be answered
  task automatic request_none(input string name);
    requestFlag = 1'b1;
    repeat (6) tick();
    check(name, dataReady, 0);
    requestFlag = 1'b0;
    tick();
  endtask

  initial begin
    int n, reqs;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_ready", dataReady, 0);
    check("rst_ninput", nInput, 0);
    check("rst_epoch", epoch, 0);
    check("rst_full", load_full, 0);
    check("rst_x1", x1Input, 0);

    // Directed set from the worked example
    load(7'sd5, -7'sd3, 2'sd1);
    load(-7'sd64, 7'sd63, -2'sd1);
    load(7'sd0, 7'sd1, 2'sd1);
    check("ninput3", nInput, 3);
    do_start();
    for (int i = 0; i < 4; i++) request_cycle(0);
    check("epoch1", epoch, 1);
    check("ninput3_serve", nInput, 3);

    // Long request hold: dataReady must stay up with stable data
    request_cycle(10);

    // done while presenting
    exp_q.push_back(mmem[midx]);
    requestFlag = 1'b1;
    repeat (3) tick();
    check("ready_before_done", dataReady, 1);
    done = 1'b1; tick(); done = 1'b0;
    check("done_ready", dataReady, 0);
    requestFlag = 1'b0;
    tick();
    request_none("done_idle");
    do_start();
    check("restart_epoch", epoch, 0);
    request_cycle(0);
    do_done();

    // Randomised sets and transfer counts
    for (int r = 0; r < 4; r++) begin
      do_clear();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++)
        load(7'($urandom), 7'($urandom), 2'($urandom));
      check("rnd_ninput", nInput, n);
      do_start();
      reqs = n + $urandom_range(1, 2*n);
      for (int k = 0; k < reqs; k++) request_cycle($urandom_range(0, 3));
      do_done();
    end

    // Fill to capacity, extra pushes dropped
    do_clear();
    for (int k = 0; k < DEPTH + 2; k++)
      load(7'($urandom), 7'($urandom), 2'($urandom));
    check("full_flag", load_full, 1);
    check("full_ninput", nInput, DEPTH);
    do_start();
    request_cycle(0);
    request_cycle(0);
    do_done();

    // start with an empty set is ignored
    do_clear();
    check("clear_ninput", nInput, 0);
    do_start();
    request_none("empty_start");

    // Reset while presenting
    load(7'sd11, 7'sd22, 2'sd1);
    load(-7'sd11, -7'sd22, -2'sd2);
    do_start();
    exp_q.push_back(mmem[midx]);
    requestFlag = 1'b1;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    requestFlag = 1'b0;
    mcount = 0;
    check("mid_rst_ready", dataReady, 0);
    check("mid_rst_ninput", nInput, 0);
    check("mid_rst_x1", x1Input, 0);
    check("mid_rst_epoch", epoch, 0);
    tick();
    do_start();
    request_none("rst_start_ignored");
    load(7'sd3, 7'sd4, 2'sd1);
    do_start();
    request_cycle(0);
    do_done();

`ifdef FEEDER_EPOCH_LIMIT_EN
    // Epoch limit: two samples, two epochs, then self-stop
    do_clear();
    epoch_limit = 16'd2;
    mlimit = 2;
    load(7'sd1, 7'sd2, 2'sd1);
    load(7'sd3, 7'sd4, -2'sd1);
    do_start();
    check("exh_clear", exhausted, 0);
    for (int i = 0; i < 4; i++) request_cycle(0);
    check("exhausted", exhausted, mexh);
    request_none("exh_no_ready");
    check("exh_sticky", exhausted, 1);
    epoch_limit = 16'd0;
    mlimit = 0;
`endif

    repeat (2) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
